// File: rtl/video_pattern_gen.sv
// Video timing and RGB test-pattern generator: HS/VS/BLANK raster timing for any
// panel geometry plus a frame-synchronous selectable pattern, all outputs registered.
module video_pattern_gen #(
  parameter int HDISP    = 800,
  parameter int VDISP    = 480,
  parameter int HFP      = 40,
  parameter int HPULSE   = 48,
  parameter int HBP      = 40,
  parameter int VFP      = 13,
  parameter int VPULSE   = 3,
  parameter int VBP      = 29,
  parameter int CBITS    = 8,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                         pixel_clk,
  input  logic                         pixel_nrst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  output logic                         HS,
  output logic                         VS,
  output logic                         BLANK,
  output logic [3*CBITS-1:0]           RGB,
  output logic [$clog2(HDISP)-1:0]     x,
  output logic [$clog2(VDISP)-1:0]     y,
  output logic                         frame_start
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);

  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC0 = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC1 = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT   = HW'(HTOTAL - HDISP);
  localparam logic [HW-1:0] BAR_W   = HW'(HDISP / 8);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC0 = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC1 = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT   = VW'(VTOTAL - VDISP);

  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [VW-1:0]      vcnt_q, vcnt_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
  logic [3*CBITS-1:0] rgb_q, rgb_d, pix;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;

  logic               h_wrap, v_wrap, frame_top, active, chk;
  logic [HW-1:0]      xa, bar_raw;
  logic [VW-1:0]      ya;
  logic [2:0]         bar_idx;

  assign h_wrap    = (hcnt_q == H_LAST);
  assign v_wrap    = (vcnt_q == V_LAST);
  assign frame_top = (hcnt_q == '0) && (vcnt_q == '0);

  // Counters park at the frame origin while disabled so enabling always starts a clean frame.
  always_comb begin
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    frame_cnt_d = frame_cnt_q;
    if (!en) begin
      hcnt_d      = '0;
      vcnt_d      = '0;
      frame_cnt_d = '0;
    end else begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        if (v_wrap) frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Pattern select only moves at the frame origin, so a frame is never drawn with two patterns.
  assign mode_d = (!en || frame_top) ? mode : mode_q;

  assign active  = (hcnt_q >= H_ACT) && (vcnt_q >= V_ACT);
  assign xa      = hcnt_q - H_ACT;
  assign ya      = vcnt_q - V_ACT;
  assign bar_raw = xa / BAR_W;
  assign bar_idx = (bar_raw > HW'(7)) ? 3'd7 : bar_raw[2:0];
  assign chk     = 1'((32'(xa) >> 4) ^ (32'(ya) >> 4));

  // Bar order white..black maps onto the inverted bits of the bar index.
  always_comb begin
    pix = '0;
    case (mode_q)
      2'd0: pix = {{CBITS{~bar_idx[1]}}, {CBITS{~bar_idx[2]}}, {CBITS{~bar_idx[0]}}};
      2'd1: pix = {(3*CBITS){chk}};
      2'd2: pix = {3{CBITS'(xa)}};
      2'd3: pix = {CBITS'({frame_cnt_q, {CBITS{1'b0}}} >> 8), CBITS'(ya), {CBITS{1'b0}}};
      default: pix = '0;
    endcase
  end

  always_comb begin
    hs_d    = ~SYNC_POL;
    vs_d    = ~SYNC_POL;
    blank_d = 1'b0;
    rgb_d   = '0;
    x_d     = '0;
    y_d     = '0;
    fs_d    = 1'b0;
    if (en) begin
      if (hcnt_q >= H_SYNC0 && hcnt_q < H_SYNC1) hs_d = SYNC_POL;
      if (vcnt_q >= V_SYNC0 && vcnt_q < V_SYNC1) vs_d = SYNC_POL;
      fs_d    = frame_top;
      blank_d = active;
      if (active) begin
        rgb_d = pix;
        x_d   = XW'(xa);
        y_d   = YW'(ya);
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_nrst) begin
    if (!pixel_nrst) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      frame_cnt_q <= '0;
      mode_q      <= '0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      fs_q        <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fs_q        <= fs_d;
    end
  end

  assign HS          = hs_q;
  assign VS          = vs_q;
  assign BLANK       = blank_q;
  assign RGB         = rgb_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule
